// File: rtl/reference_reader.sv
// Streams BUFFER_LENGTH reference samples from a read-addressed buffer into an AXI-Stream output.
// Optional REFERENCE_READER_REPEAT_EN adds repeat_count for back-to-back multi-pass playback.
module reference_reader #(
  parameter int I_BITS        = 8,
  parameter int Q_BITS        = 8,
  parameter int INDEX_BITS    = 10,
  parameter int BUFFER_LENGTH = 1000
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         start,
`ifdef REFERENCE_READER_REPEAT_EN
  input  logic [7:0]                   repeat_count,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [INDEX_BITS-1:0]        m_axi_ref_raddr,
  output logic                         m_axi_ref_rvalid,
  output logic                         m_axi_ref_rready,
  input  logic                         s_axi_ref_rready,
  input  logic                         s_axi_ref_rvalid,
  input  logic signed [I_BITS-1:0]     ref_i,
  input  logic signed [Q_BITS-1:0]     ref_q,
  output logic                         m_axis_ref_tvalid,
  input  logic                         m_axis_ref_tready,
  output logic signed [I_BITS-1:0]     m_axis_ref_i,
  output logic signed [Q_BITS-1:0]     m_axis_ref_q,
  output logic                         m_axis_ref_tlast
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(BUFFER_LENGTH - 1);

  logic [1:0]               state;
  logic [2:0]               outstanding;
  logic [2:0]               fifo_count;
  logic [1:0]               wr_ptr;
  logic [1:0]               rd_ptr;
  logic signed [I_BITS-1:0] fifo_i [4];
  logic signed [Q_BITS-1:0] fifo_q [4];
  logic [3:0]               fifo_last;
  logic                     issue;
  logic                     push;
  logic                     pop;
  logic                     resp_last;
  logic                     last_pass;
  logic                     head_last;

`ifdef REFERENCE_READER_REPEAT_EN
  logic [7:0] passes_left;
  assign last_pass = (passes_left == 8'd0);
`else
  assign last_pass = 1'b1;
`endif

  // Credit check keeps FIFO room for every in-flight response.
  assign m_axi_ref_rvalid = (state == FETCH) &&
                            (({1'b0, fifo_count} + {1'b0, outstanding}) < 4'd4);
  assign m_axi_ref_rready = m_axi_ref_rvalid;
  assign busy             = (state != IDLE);

  assign issue = m_axi_ref_rvalid && s_axi_ref_rready;
  // Responses with nothing outstanding are stale (e.g. from a pass abandoned by reset).
  assign push  = s_axi_ref_rvalid && (outstanding != 3'd0);
  assign pop   = m_axis_ref_tvalid && m_axis_ref_tready;
  // Once in DRAIN no more requests go out, so the last outstanding response is the final sample.
  assign resp_last = (state == DRAIN) && (outstanding == 3'd1);

  assign head_last         = fifo_last[rd_ptr];
  assign m_axis_ref_tvalid = (fifo_count != 3'd0);
  assign m_axis_ref_tlast  = m_axis_ref_tvalid && head_last;
  assign m_axis_ref_i      = m_axis_ref_tvalid ? fifo_i[rd_ptr] : '0;
  assign m_axis_ref_q      = m_axis_ref_tvalid ? fifo_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_i[wr_ptr]    <= ref_i;
      fifo_q[wr_ptr]    <= ref_q;
      fifo_last[wr_ptr] <= resp_last;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      case ({issue, push})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state           <= IDLE;
      m_axi_ref_raddr <= '0;
      done            <= 1'b0;
`ifdef REFERENCE_READER_REPEAT_EN
      passes_left     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state           <= FETCH;
            m_axi_ref_raddr <= '0;
`ifdef REFERENCE_READER_REPEAT_EN
            passes_left     <= repeat_count;
`endif
          end
        end
        FETCH: begin
          if (issue) begin
            if (m_axi_ref_raddr == LAST_IDX) begin
              m_axi_ref_raddr <= '0;
              if (last_pass) state <= DRAIN;
`ifdef REFERENCE_READER_REPEAT_EN
              else passes_left <= passes_left - 8'd1;
`endif
            end else begin
              m_axi_ref_raddr <= m_axi_ref_raddr + INDEX_BITS'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reference_reader.md
REFERENCE_READER -- requirements
Module: reference_reader

Interface
REQ-001 SHALL have parameter I_BITS, default 8, meaning width of the signed ref_i sample.
REQ-002 SHALL have parameter Q_BITS, default 8, meaning width of the signed ref_q sample.
REQ-003 SHALL have parameter INDEX_BITS, default 10, meaning width of the buffer read address.
REQ-004 SHALL have parameter BUFFER_LENGTH, default 1000, meaning number of samples per pass, with 1 <= BUFFER_LENGTH <= 2^INDEX_BITS.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port n_reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, pass request, sampled in IDLE only.
REQ-008 SHALL have ports busy, output, 1, high in any state other than IDLE; and done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports m_axi_ref_raddr, output, INDEX_BITS; m_axi_ref_rvalid, output, 1; m_axi_ref_rready, output, 1; these form the read request to the reference buffer.
REQ-010 SHALL have ports s_axi_ref_rready, input, 1, buffer accepts request; s_axi_ref_rvalid, input, 1, response valid; ref_i, input, I_BITS signed; ref_q, input, Q_BITS signed.
REQ-011 SHALL have ports m_axis_ref_tvalid, output, 1; m_axis_ref_tready, input, 1; m_axis_ref_i, output, I_BITS signed; m_axis_ref_q, output, Q_BITS signed; m_axis_ref_tlast, output, 1; these form the downstream sample stream.

Function
REQ-012 SHALL implement states IDLE, FETCH, DRAIN; start in IDLE moves to FETCH with raddr=0; start outside IDLE is ignored.
REQ-013 SHALL count a request as issued on a cycle with m_axi_ref_rvalid && s_axi_ref_rready, then increment raddr.
REQ-014 SHALL hold m_axi_ref_rready high whenever m_axi_ref_rvalid is high.
REQ-015 SHALL capture ref_i/ref_q into a 4-entry output FIFO on every cycle s_axi_ref_rvalid is high, in request order.
REQ-016 SHALL assert m_axi_ref_rvalid in FETCH only while FIFO occupancy plus outstanding requests is less than 4, so that a response is never dropped.
REQ-017 SHALL sustain one sample per cycle when the buffer responds in 1 cycle and m_axis_ref_tready stays high.
REQ-018 SHALL move FETCH to DRAIN in the cycle after the request for index BUFFER_LENGTH-1 is issued.
REQ-019 SHALL present the FIFO head on m_axis_ref_i/q with tvalid = FIFO not empty, and pop on tvalid && tready; data SHALL stay stable while tvalid is high and tready is low.
REQ-020 SHALL assert m_axis_ref_tlast with the final sample of the run only.
REQ-021 SHALL move DRAIN to IDLE and pulse done for exactly one cycle when the tlast beat is accepted and the FIFO is empty.
REQ-022 SHALL support a simultaneous FIFO push and pop, leaving occupancy unchanged; push into a full FIFO is impossible by REQ-016.
REQ-023 SHALL allow a new start in the cycle immediately after done.

Reset
REQ-024 SHALL on n_reset low, immediately and regardless of clock, enter IDLE and clear the FIFO and outstanding count.
REQ-025 SHALL on n_reset low drive raddr=0 and busy, done, m_axi_ref_rvalid, m_axi_ref_rready, m_axis_ref_tvalid, m_axis_ref_tlast low, with m_axis_ref_i and m_axis_ref_q at 0.
REQ-026 SHALL on reset mid-pass abandon the pass with no done pulse, and discard responses arriving after release until the next start.

Configuration
REQ-027 SHALL use macro REFERENCE_READER_REPEAT_EN; when defined, it adds input repeat_count, 8 bits, latched at start, giving repeat_count+1 passes.
REQ-028 SHALL with REFERENCE_READER_REPEAT_EN defined wrap raddr from BUFFER_LENGTH-1 to 0 without a bubble, and assert tlast only on the last sample of the last pass.
REQ-029 SHALL with REFERENCE_READER_REPEAT_EN undefined omit the repeat_count port and run exactly one pass per start.

Verification
REQ-030 SHALL cover: BUFFER_LENGTH=8, buffer holding i=k and q=-k, start pulse with tready=1 -> 8 beats (0,0)..(7,-7) on consecutive cycles, tlast on beat 7, and done one cycle later.
REQ-031 SHALL cover: tready held low for 10 cycles after start -> exactly 4 requests issued, tvalid high, and head (0,0) stable; on tready release the stream completes in order.
REQ-032 SHALL cover: start asserted again mid-pass -> no effect on raddr, and exactly 8 beats with a single done.
REQ-033 SHALL cover: n_reset low after beat 3 -> all outputs at reset values that same cycle, no done; a later start produces a full 0..7 run.
REQ-034 SHALL cover: REFERENCE_READER_REPEAT_EN defined, repeat_count=2 -> 24 beats with index sequence 0..7 three times and tlast only on beat 23.
REQ-035 SHALL cover: s_axi_ref_rready toggling every other cycle -> no lost or duplicated samples and the order preserved.
